// File: rtl/image_loader.sv
// ============================================================================
// Module   : image_loader
// Purpose  : Ping-pong ingest buffer: streams image words in, serves frames out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_loader #(
  parameter int INPUT_HEIGHT = 28,
  parameter int INPUT_WIDTH  = 28,
  parameter int INPUT_DEPTH  = 3,
  parameter int VALUE_BITS   = 32,
  localparam int N  = INPUT_HEIGHT * INPUT_WIDTH * INPUT_DEPTH,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_BITS-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  frame_valid,
  input  logic [AW-1:0]         rd_addr,
  output logic [VALUE_BITS-1:0] rd_data,
  input  logic                  frame_release,
  output logic [15:0]           frame_count
);

  localparam logic [AW-1:0] C_LAST_PTR = AW'(N - 1);

  logic [VALUE_BITS-1:0] r_bank0 [0:N-1];
  logic [VALUE_BITS-1:0] r_bank1 [0:N-1];

  logic          r_wr_bank;
  logic [AW-1:0] r_wr_ptr;
  logic          r_rd_bank;
  logic [1:0]    r_full;
  logic [15:0]   r_frame_count;

  logic       w_accept;
  logic       w_complete;
  logic       w_release;
  logic [1:0] w_full_nxt;

  // Ready/valid derive only from registers, so no input-to-output comb path.
  assign s_ready     = !r_full[r_wr_bank];
  assign frame_valid = r_full[r_rd_bank];
  assign frame_count = r_frame_count;

  always_comb begin
    w_accept   = s_valid && s_ready;
    w_complete = w_accept && (r_wr_ptr == C_LAST_PTR);
    w_release  = frame_release && r_full[r_rd_bank];
    w_full_nxt = r_full;
    // Completion and release always target different banks.
    if (w_complete) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)  w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_wr_bank) r_bank1[r_wr_ptr] <= s_data;
      else           r_bank0[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_rd_bank ? r_bank1[rd_addr] : r_bank0[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_bank     <= 1'b0;
      r_full        <= 2'b00;
      r_frame_count <= 16'd0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        if (w_complete) begin
          r_wr_ptr      <= '0;
          r_wr_bank     <= ~r_wr_bank;
          r_frame_count <= r_frame_count + 16'd1;
        end else begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

endmodule

`default_nettype wire
